// File: rtl/pkt_to_msg.sv
// ============================================================================
// Module   : pkt_to_msg
// Purpose  : Reassembles router flits into a Wishbone message.
//            The head flit supplies the address, the source tag (TGA) and the
//            command tag (TGC). The finished message is held stable until the
//            consumer acknowledges it.
// Options  : PKT_TO_MSG_LEN_ERR_EN adds len_err_o, which flags packets
//            longer than MAX_PACKET_LENGTH.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pkt_to_msg #(
  parameter int FLIT_WIDTH        = 64,
  parameter int MAX_PACKET_LENGTH = 4,
  parameter int ADDR_WIDTH        = 32,
  parameter int TGA_WIDTH         = 8,
  parameter int TGC_WIDTH         = 4
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [FLIT_WIDTH-1:0]                   flit_i,
  input  logic                                    flit_valid_i,
  input  logic                                    flit_tail_i,
  output logic                                    flit_ready_o,
  output logic [MAX_PACKET_LENGTH*FLIT_WIDTH-1:0] data_o,
  output logic [ADDR_WIDTH-1:0]                   address_o,
  output logic [TGA_WIDTH-1:0]                    tga_o,
  output logic [TGC_WIDTH-1:0]                    tgc_o,
  output logic                                    we_o,
  output logic [$clog2(MAX_PACKET_LENGTH):0]      flit_count_o,
  output logic                                    msg_valid_o,
  input  logic                                    msg_ack_i
`ifdef PKT_TO_MSG_LEN_ERR_EN
  ,
  output logic                                    len_err_o
`endif
);

  localparam int CNT_W = $clog2(MAX_PACKET_LENGTH) + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   accept;
  logic   full;

  assign flit_ready_o = (state != HOLD);
  assign accept       = flit_valid_i & flit_ready_o;
  assign full         = (flit_count_o == CNT_W'(MAX_PACKET_LENGTH));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode: the head opens a packet, the tail closes it, and the ack releases HOLD.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) state_nxt = flit_tail_i ? HOLD : COLLECT;
      end
      COLLECT: begin
        if (accept && flit_tail_i) state_nxt = HOLD;
      end
      HOLD: begin
        if (msg_ack_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Message datapath: decode the head, store the body flits in order, and drop any excess.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_o       <= '0;
      address_o    <= '0;
      tga_o        <= '0;
      tgc_o        <= '0;
      we_o         <= 1'b0;
      flit_count_o <= '0;
      msg_valid_o  <= 1'b0;
    end else begin
      msg_valid_o <= (state_nxt == HOLD);
      if (state == IDLE && accept) begin
        // Clear the data first so that short packets read zero in their unused slots.
        data_o                   <= '0;
        data_o[FLIT_WIDTH-1:0]   <= flit_i;
        address_o                <= flit_i[ADDR_WIDTH-1:0];
        tga_o                    <= flit_i[ADDR_WIDTH +: TGA_WIDTH];
        tgc_o                    <= flit_i[ADDR_WIDTH+TGA_WIDTH +: TGC_WIDTH];
        we_o                     <= flit_i[ADDR_WIDTH+TGA_WIDTH];
        flit_count_o             <= CNT_W'(1);
      end else if (state == COLLECT && accept && !full) begin
        for (int k = 1; k < MAX_PACKET_LENGTH; k++) begin
          if (flit_count_o == CNT_W'(k)) data_o[k*FLIT_WIDTH +: FLIT_WIDTH] <= flit_i;
        end
        flit_count_o <= flit_count_o + CNT_W'(1);
      end
    end
  end

`ifdef PKT_TO_MSG_LEN_ERR_EN
  logic overflow;
  logic overflow_now;

  // True on the edge that drops a flit because the buffer is already full.
  assign overflow_now = (state == COLLECT) && accept && full;

  // Overflow tracking: a sticky flag per packet, reported alongside msg_valid_o.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      len_err_o <= 1'b0;
    end else begin
      if (state == IDLE && accept) overflow <= 1'b0;
      else if (overflow_now)       overflow <= 1'b1;

      if (state != HOLD && state_nxt == HOLD) len_err_o <= overflow | overflow_now;
      else if (state == HOLD && msg_ack_i)    len_err_o <= 1'b0;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_pkt_to_msg.sv
// ============================================================================
// Module   : tb_pkt_to_msg
// Purpose  : Self-checking bench for pkt_to_msg. It uses random packets and
//            compares the DUT against a packet-level reference model.
// Options  : Checks len_err_o when PKT_TO_MSG_LEN_ERR_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pkt_to_msg;

  localparam int FW   = 64;
  localparam int MAXL = 4;
  localparam int NW   = 3;
  localparam int OW   = MAXL*FW + 32 + 8 + 4 + 1 + NW + 1;

  typedef logic [FW-1:0] flit_t;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [FW-1:0]        flit_i = '0;
  logic                 flit_valid_i = 1'b0;
  logic                 flit_tail_i = 1'b0;
  logic                 flit_ready_o;
  logic [MAXL*FW-1:0]   data_o;
  logic [31:0]          address_o;
  logic [7:0]           tga_o;
  logic [3:0]           tgc_o;
  logic                 we_o;
  logic [NW-1:0]        flit_count_o;
  logic                 msg_valid_o;
  logic                 msg_ack_i = 1'b0;
`ifdef PKT_TO_MSG_LEN_ERR_EN
  logic                 len_err_o;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [OW-1:0] obs;
  logic [OW-1:0] exp_v;

  always #5 clk = ~clk;

  assign obs = {data_o, address_o, tga_o, tgc_o, we_o, flit_count_o, msg_valid_o};

  pkt_to_msg #(
    .FLIT_WIDTH(FW), .MAX_PACKET_LENGTH(MAXL), .ADDR_WIDTH(32), .TGA_WIDTH(8), .TGC_WIDTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flit_i(flit_i), .flit_valid_i(flit_valid_i),
    .flit_tail_i(flit_tail_i), .flit_ready_o(flit_ready_o), .data_o(data_o),
    .address_o(address_o), .tga_o(tga_o), .tgc_o(tgc_o), .we_o(we_o),
    .flit_count_o(flit_count_o), .msg_valid_o(msg_valid_o), .msg_ack_i(msg_ack_i)
`ifdef PKT_TO_MSG_LEN_ERR_EN
    , .len_err_o(len_err_o)
`endif
  );

  // Reference model: the expected message for a whole packet, derived from its flit list.
  function automatic logic [OW-1:0] model_msg(input flit_t q[$], input logic valid);
    logic [MAXL*FW-1:0] d;
    flit_t head;
    int kept;
    d    = '0;
    head = q[0];
    kept = (q.size() > MAXL) ? MAXL : q.size();
    for (int i = 0; i < kept; i++) d[i*FW +: FW] = q[i];
    return {d, head[31:0], head[39:32], head[43:40], head[40], NW'(kept), valid};
  endfunction

  function automatic flit_t rnd_flit();
    return {$urandom(), $urandom()};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pkt(input flit_t q[$], input int gap_after, input int gap_len);
    for (int i = 0; i < q.size(); i++) begin
      int budget;
      budget       = 0;
      flit_valid_i = 1'b1;
      flit_i       = q[i];
      flit_tail_i  = (i == q.size() - 1);
      while (!flit_ready_o && budget < 50) begin
        tick();
        budget++;
      end
      if (!flit_ready_o) begin
        n_cmp++; n_err++;
        $display("FAIL ready_timeout: flit_ready_o=%b required 1", flit_ready_o);
      end
      tick();
      flit_valid_i = 1'b0;
      flit_tail_i  = 1'b0;
      if (i == gap_after) repeat (gap_len) tick();
    end
  endtask

  task automatic do_ack();
    msg_ack_i = 1'b1;
    tick();
    msg_ack_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    n_cmp++;
    if (obs !== '0) begin
      n_err++; $display("FAIL reset_outputs: got %h required 0", obs);
    end
    n_cmp++;
    if (flit_ready_o !== 1'b1) begin
      n_err++; $display("FAIL reset_ready: got %b required 1", flit_ready_o);
    end
`ifdef PKT_TO_MSG_LEN_ERR_EN
    n_cmp++;
    if (len_err_o !== 1'b0) begin
      n_err++; $display("FAIL reset_len_err: got %b required 0", len_err_o);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    flit_t q[$];
    q = {64'h0000_0C05_1000_0040};
    drive_pkt(q, -1, 0);
    exp_v = {256'h0000_0C05_1000_0040, 32'h1000_0040, 8'h05, 4'hC, 1'b0, 3'd1, 1'b1};
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++; $display("FAIL single_decode: got %h required %h", obs, exp_v);
    end
    n_cmp++;
    if (flit_ready_o !== 1'b0) begin
      n_err++; $display("FAIL single_hold_ready: got %b required 0", flit_ready_o);
    end
    do_ack();
    n_cmp++;
    if (msg_valid_o !== 1'b0 || flit_ready_o !== 1'b1) begin
      n_err++; $display("FAIL single_ack: valid=%b ready=%b required 0/1", msg_valid_o, flit_ready_o);
    end
  endtask

  task automatic test_gap_write();
    flit_t q[$];
    flit_t a;
    a = rnd_flit();
    a[40] = 1'b1;
    q = {a, rnd_flit(), rnd_flit()};
    drive_pkt(q, 1, 2);
    exp_v = model_msg(q, 1'b1);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++; $display("FAIL gap_write_msg: got %h required %h", obs, exp_v);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      n_cmp++;
      if (flit_ready_o !== 1'b0 || obs !== exp_v) begin
        n_err++; $display("FAIL gap_write_hold: ready=%b got %h required 0 / %h", flit_ready_o, obs, exp_v);
      end
    end
    do_ack();
    exp_v = model_msg(q, 1'b0);
    n_cmp++;
    if (obs !== exp_v || flit_ready_o !== 1'b1) begin
      n_err++; $display("FAIL gap_write_ack: ready=%b got %h required 1 / %h", flit_ready_o, obs, exp_v);
    end
  endtask

  task automatic test_back_to_back();
    flit_t q1[$];
    flit_t q2[$];
    q1 = {rnd_flit(), rnd_flit()};
    q2 = {rnd_flit()};
    drive_pkt(q1, -1, 0);
    exp_v = model_msg(q1, 1'b1);
    flit_valid_i = 1'b1; flit_i = q2[0]; flit_tail_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if (flit_ready_o !== 1'b0 || obs !== exp_v) begin
        n_err++; $display("FAIL b2b_hold: ready=%b got %h required 0 / %h", flit_ready_o, obs, exp_v);
      end
    end
    do_ack();
    exp_v = model_msg(q1, 1'b0);
    n_cmp++;
    if (obs !== exp_v || flit_ready_o !== 1'b1) begin
      n_err++; $display("FAIL b2b_ack: ready=%b got %h required 1 / %h", flit_ready_o, obs, exp_v);
    end
    tick();
    flit_valid_i = 1'b0; flit_tail_i = 1'b0;
    exp_v = model_msg(q2, 1'b1);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++; $display("FAIL b2b_second: got %h required %h", obs, exp_v);
    end
    do_ack();
  endtask

  task automatic test_overflow();
    flit_t q[$];
    for (int i = 0; i < 6; i++) q.push_back(rnd_flit());
    drive_pkt(q, -1, 0);
    exp_v = model_msg(q, 1'b1);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++; $display("FAIL overflow_msg: got %h required %h", obs, exp_v);
    end
`ifdef PKT_TO_MSG_LEN_ERR_EN
    n_cmp++;
    if (len_err_o !== 1'b1) begin
      n_err++; $display("FAIL overflow_len_err: got %b required 1", len_err_o);
    end
`endif
    do_ack();
`ifdef PKT_TO_MSG_LEN_ERR_EN
    n_cmp++;
    if (len_err_o !== 1'b0) begin
      n_err++; $display("FAIL overflow_len_err_clear: got %b required 0", len_err_o);
    end
`endif
  endtask

  task automatic test_async_reset();
    flit_t q[$];
    q = {rnd_flit(), rnd_flit(), rnd_flit(), rnd_flit()};
    flit_valid_i = 1'b1; flit_i = q[0];
    tick();
    flit_i = q[1];
    tick();
    flit_valid_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (obs !== '0 || flit_ready_o !== 1'b1) begin
      n_err++; $display("FAIL async_reset: ready=%b got %h required 1 / 0", flit_ready_o, obs);
    end
    #2 rst_n = 1'b1;
    q = {rnd_flit()};
    drive_pkt(q, -1, 0);
    exp_v = model_msg(q, 1'b1);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++; $display("FAIL async_reset_fresh: got %h required %h", obs, exp_v);
    end
    do_ack();
  endtask

  task automatic test_random();
    for (int p = 0; p < 30; p++) begin
      flit_t q[$];
      int n;
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) q.push_back(rnd_flit());
      drive_pkt(q, (n > 1) ? int'($urandom_range(0, n - 2)) : -1, $urandom_range(0, 3));
      exp_v = model_msg(q, 1'b1);
      n_cmp++;
      if (obs !== exp_v) begin
        n_err++; $display("FAIL random_msg[%0d]: got %h required %h", p, obs, exp_v);
      end
`ifdef PKT_TO_MSG_LEN_ERR_EN
      n_cmp++;
      if (len_err_o !== (n > MAXL)) begin
        n_err++; $display("FAIL random_len_err[%0d]: got %b required %b", p, len_err_o, (n > MAXL));
      end
`endif
      repeat ($urandom_range(0, 3)) tick();
      n_cmp++;
      if (flit_ready_o !== 1'b0 || msg_valid_o !== 1'b1) begin
        n_err++; $display("FAIL random_hold[%0d]: ready=%b valid=%b required 0/1", p, flit_ready_o, msg_valid_o);
      end
      do_ack();
      n_cmp++;
      if (msg_valid_o !== 1'b0) begin
        n_err++; $display("FAIL random_ack[%0d]: valid=%b required 0", p, msg_valid_o);
      end
    end
  endtask

  // Test sequence.
  initial begin
    test_reset();
    test_single();
    test_gap_write();
    test_back_to_back();
    test_overflow();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pkt_to_msg.md
Name: pkt_to_msg

Overview:
- Receive-side counterpart of the NIC message-to-packet path.
- Accepts flits from the router ejection port one per cycle, reassembles the packet, and decodes the head flit into address, source tag (TGA) and command tag (TGC).
- Holds the rebuilt Wishbone message stable until the downstream WB master/slave interface acknowledges it.
- Sits between the router ejection FIFO and the NIC's WB interfaces.

Parameters:
- FLIT_WIDTH, 64, bits per flit.
- MAX_PACKET_LENGTH, 4, flits stored per packet; also the maximum burst length in words.
- ADDR_WIDTH, 32, head-flit address field width, at bits [ADDR_WIDTH-1:0].
- TGA_WIDTH, 8, source field width, directly above the address field.
- TGC_WIDTH, 4, command field width, directly above the source field; TGC bit 0 = WE.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flit_i  in  FLIT_WIDTH  incoming flit.
- flit_valid_i  in  1  flit_i valid this cycle.
- flit_tail_i  in  1  flit_i is the last flit of its packet; a single-flit packet asserts it on the head flit.
- flit_ready_o  out  1  block can accept a flit this cycle.
- data_o  out  MAX_PACKET_LENGTH*FLIT_WIDTH  reassembled packet; flit k at [k*FLIT_WIDTH +: FLIT_WIDTH].
- address_o  out  ADDR_WIDTH  address decoded from the head flit.
- tga_o  out  TGA_WIDTH  source decoded from the head flit.
- tgc_o  out  TGC_WIDTH  command decoded from the head flit.
- we_o  out  1  equals tgc_o[0].
- flit_count_o  out  clog2(MAX_PACKET_LENGTH)+1  number of flits stored, 1..MAX_PACKET_LENGTH.
- msg_valid_o  out  1  message complete and stable.
- msg_ack_i  in  1  consumer has taken the message.
- len_err_o  out  1  packet exceeded MAX_PACKET_LENGTH; present only with the optional feature.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; every output register is cleared (data_o, address_o, tga_o, tgc_o, we_o, flit_count_o, msg_valid_o, len_err_o = 0). flit_ready_o is decoded from state, so it is 1 in IDLE. Reset mid-packet or mid-HOLD discards the partial or held message; no output glitches to a stale message afterwards.
- A flit is accepted on any edge where flit_valid_i & flit_ready_o; flit_ready_o = (state != HOLD).
- IDLE:
  - On head accept: clear data_o; store the flit at slot 0; latch address_o/tga_o/tgc_o/we_o from the head field positions; flit_count_o = 1.
  - If flit_tail_i is set, go to HOLD; otherwise go to COLLECT.
- COLLECT:
  - Each accepted flit is stored at slot flit_count_o, then flit_count_o increments.
  - Once flit_count_o == MAX_PACKET_LENGTH, further flits are accepted but not stored; the count saturates and an overflow flag is set.
  - Tail accept moves to HOLD.
  - Cycles with flit_valid_i low simply wait; there is no timeout.
- HOLD:
  - msg_valid_o = 1 (registered, first high in the cycle after the tail-accept edge); flit_ready_o = 0.
  - All message outputs are frozen.
  - msg_ack_i high on an edge moves to IDLE: msg_valid_o = 0 and flit_ready_o = 1 from the next cycle. The held data is not cleared until the next head arrives.
- Latency: tail accepted at edge N gives msg_valid_o high after edge N. Minimum packet-to-packet spacing is 1 idle cycle (the ack edge).
- msg_ack_i outside HOLD is ignored.
- Unused slots of data_o read 0.
- No field is interpreted beyond the head flit. Read requests are 1-flit packets; write/reply packets carry data in all flits including the head.

Optional Feature:
- Macro PKT_TO_MSG_LEN_ERR_EN.
- Defined:
  - len_err_o exists.
  - It is set together with msg_valid_o when the overflow flag was set for the packet, and cleared with msg_valid_o on ack.
  - The truncated message is still delivered.
- Undefined:
  - len_err_o is absent and the overflow flag logic is removed.
  - Excess flits are silently dropped; all other behaviour is identical.

Test Plan:
- Reset → all outputs 0, flit_ready_o = 1. Then a single flit 0x0000_0C05_1000_0040 with tail → after 1 edge: address_o = 0x10000040, tga_o = 0x05, tgc_o = 0xC, we_o = 0, flit_count_o = 1, msg_valid_o = 1.
- 3-flit write packet (head tgc_o[0] = 1, flits A, B, C; tail on C) with a 2-cycle valid gap after B → data_o = {0, C, B, A}, flit_count_o = 3, we_o = 1. flit_ready_o = 0 until msg_ack_i; msg_ack_i high 4 cycles later → msg_valid_o = 0 the next cycle.
- Back-to-back: a second packet is presented while in HOLD → it is not accepted until the ack edge, then accepted on the first IDLE cycle; the first message stays unchanged throughout HOLD.
- 6-flit packet with MAX_PACKET_LENGTH = 4 → flits 0-3 stored, flit_count_o = 4, msg_valid_o after the 6th flit; len_err_o = 1 with PKT_TO_MSG_LEN_ERR_EN, and the port is absent without it.
- rst_n pulsed low asynchronously after flit 2 of 4 → outputs 0 immediately; a fresh 1-flit packet afterwards decodes correctly with no leftover data in slots 1-3.
